// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - elastic valid/ready pipeline register chain with flush and occupancy
// Stage 0 faces the producer, stage DEPTH-1 drives out_*; state updates on the falling edge.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    occupancy
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] acc;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] valid_nxt;
  logic [WIDTH-1:0] data    [DEPTH];
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [CW-1:0]    occ_nxt;

  // A stage can take new content if it is empty or its own content moves on.
  always_comb begin
    acc = '0;
    acc[DEPTH-1] = ~valid[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      acc[i] = ~valid[i] | acc[i+1];
    end
  end

  always_comb begin
    up_valid    = '0;
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid[i] = valid[i-1];
      up_data[i]  = data[i-1];
    end
  end

  always_comb begin
    valid_nxt = '0;
    occ_nxt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!flush) begin
        valid_nxt[i] = acc[i] ? up_valid[i] : valid[i];
      end
      occ_nxt = occ_nxt + CW'(valid_nxt[i]);
    end
  end

  assign in_ready  = acc[0] & ~flush;
  assign out_valid = valid[DEPTH-1] & ~flush;
  assign out_data  = data[DEPTH-1];

  // Bubbles move valid=0 forward but leave the stale payload in place.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      valid     <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else begin
      valid     <= valid_nxt;
      occupancy <= occ_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          data[i] <= '0;
        end else if (acc[i] && up_valid[i]) begin
          data[i] <= up_data[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed self-checking bench for pipe_stage_chain
// Two instances share stimulus: DEPTH=3 for most cases, DEPTH=1 for the full-chain swap.
module tb_pipe_stage_chain;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready3, out_valid3;
  logic [31:0] out_data3;
  logic [1:0]  occupancy3;
  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [0:0]  occupancy1;

  logic        pre_in_ready3, pre_out_valid3, pre_in_ready1, pre_out_valid1;
  logic [31:0] pre_out_data3, pre_out_data1;

  int n_checks;
  int n_fail;

  pipe_stage_chain #(.WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready),
    .occupancy(occupancy3)
  );

  pipe_stage_chain #(.WIDTH(32), .DEPTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
    .occupancy(occupancy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive after the rising edge, snapshot combinational outputs, then settle past the falling edge.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
    @(posedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    pre_in_ready3  = in_ready3;
    pre_out_valid3 = out_valid3;
    pre_out_data3  = out_data3;
    pre_in_ready1  = in_ready1;
    pre_out_valid1 = out_valid1;
    pre_out_data1  = out_data1;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_occ", 32'(occupancy3), 32'd0);
    check("rst_out_valid", 32'(out_valid3), 32'd0);
    check("rst_out_data", out_data3, 32'h0);
    @(posedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready3), 32'd1);

    // Mid-stream reset with two entries in flight (E1 at output, E2 at input stage)
    cycle(1'b1, 32'hE1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0,  1'b0, 1'b0);
    cycle(1'b0, 32'h0,  1'b0, 1'b0);
    cycle(1'b1, 32'hE2, 1'b0, 1'b0);
    check("mid_occ", 32'(occupancy3), 32'd2);
    check("mid_out_data", out_data3, 32'hE1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_occ", 32'(occupancy3), 32'd0);
    check("arst_out_valid", 32'(out_valid3), 32'd0);
    check("arst_out_data", out_data3, 32'h0);
    @(posedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready3), 32'd1);

    // Streaming with out_ready held high
    cycle(1'b1, 32'h11, 1'b1, 1'b0);
    check("str_occ1", 32'(occupancy3), 32'd1);
    check("str_no_out_e1", 32'(out_valid3), 32'd0);
    cycle(1'b1, 32'h22, 1'b1, 1'b0);
    check("str_no_out_e2", 32'(out_valid3), 32'd0);
    cycle(1'b1, 32'h33, 1'b1, 1'b0);
    check("str_first_valid", 32'(out_valid3), 32'd1);
    check("str_first_data", out_data3, 32'h11);
    check("str_occ3", 32'(occupancy3), 32'd3);
    cycle(1'b1, 32'h44, 1'b1, 1'b0);
    check("str_acc44", 32'(pre_in_ready3), 32'd1);
    check("str_data22", out_data3, 32'h22);
    check("str_occ_steady", 32'(occupancy3), 32'd3);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("str_data33", out_data3, 32'h33);
    check("str_occ2", 32'(occupancy3), 32'd2);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("str_data44", out_data3, 32'h44);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("str_drained", 32'(out_valid3), 32'd0);
    check("str_occ0", 32'(occupancy3), 32'd0);

    // Backpressure: three acceptances fill the chain, the fourth waits
    cycle(1'b1, 32'hA1, 1'b0, 1'b0);
    cycle(1'b1, 32'hA2, 1'b0, 1'b0);
    cycle(1'b1, 32'hA3, 1'b0, 1'b0);
    check("bp_occ_full", 32'(occupancy3), 32'd3);
    cycle(1'b1, 32'hA4, 1'b0, 1'b0);
    check("bp_in_ready_low", 32'(pre_in_ready3), 32'd0);
    check("bp_occ_hold", 32'(occupancy3), 32'd3);
    cycle(1'b1, 32'hA4, 1'b1, 1'b0);
    check("bp_acc_a4", 32'(pre_in_ready3), 32'd1);
    check("bp_out_a1", pre_out_data3, 32'hA1);
    cycle(1'b1, 32'hA5, 1'b1, 1'b0);
    check("bp_acc_a5", 32'(pre_in_ready3), 32'd1);
    check("bp_out_a2", pre_out_data3, 32'hA2);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_out_a3", pre_out_data3, 32'hA3);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_out_a4", pre_out_data3, 32'hA4);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_out_a5", pre_out_data3, 32'hA5);
    check("bp_a5_valid", 32'(pre_out_valid3), 32'd1);
    check("bp_empty", 32'(out_valid3), 32'd0);

    // Bubble compression under a stalled output
    cycle(1'b1, 32'h01, 1'b0, 1'b0);
    cycle(1'b0, 32'h0,  1'b0, 1'b0);
    cycle(1'b1, 32'h02, 1'b0, 1'b0);
    check("bub_occ2", 32'(occupancy3), 32'd2);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("bub_occ_hold", 32'(occupancy3), 32'd2);
    check("bub_out01", out_data3, 32'h01);
    check("bub_in_ready", 32'(in_ready3), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("bub_rel_01", pre_out_data3, 32'h01);
    check("bub_next_02", out_data3, 32'h02);
    check("bub_next_valid", 32'(out_valid3), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("bub_occ0", 32'(occupancy3), 32'd0);

    // Flush on a full chain with live handshakes
    cycle(1'b1, 32'hB1, 1'b0, 1'b0);
    cycle(1'b1, 32'hB2, 1'b0, 1'b0);
    cycle(1'b1, 32'hB3, 1'b0, 1'b0);
    check("fl_full", 32'(occupancy3), 32'd3);
    cycle(1'b1, 32'hB4, 1'b1, 1'b1);
    check("fl_in_ready", 32'(pre_in_ready3), 32'd0);
    check("fl_out_valid", 32'(pre_out_valid3), 32'd0);
    check("fl_occ0", 32'(occupancy3), 32'd0);
    check("fl_data0", out_data3, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("fl_after_valid", 32'(out_valid3), 32'd0);
    check("fl_after_occ", 32'(occupancy3), 32'd0);

    // DEPTH=1: simultaneous consume and capture on a full chain
    do_reset();
    cycle(1'b1, 32'hC1, 1'b0, 1'b0);
    check("d1_occ1", 32'(occupancy1), 32'd1);
    check("d1_full_ready", 32'(in_ready1), 32'd0);
    cycle(1'b1, 32'hC2, 1'b1, 1'b0);
    check("d1_in_ready", 32'(pre_in_ready1), 32'd1);
    check("d1_out_c1", pre_out_data1, 32'hC1);
    check("d1_out_c2", out_data1, 32'hC2);
    check("d1_occ_stay", 32'(occupancy1), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("d1_pre_c2_valid", 32'(pre_out_valid1), 32'd1);
    check("d1_occ0", 32'(occupancy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
